pipeline_skid_register: RTL and testbench
=========================================

// Module: pipeline_skid_register
// PURPOSE
//  Parametrised elastic pipeline stage replacing fixed stall/flush stage registers.
//  Carries one opaque payload bus between pipeline stages with a valid/ready handshake.
//  A 2-entry skid buffer keeps full throughput with a registered (non-combinational) in_ready.
//  Flush inserts a bubble whose payload is BUBBLE_DATA (e.g. encoded ADDI x0,x0,0 fields).
// PARAMETERS
//  DATA_WIDTH   64             payload width in bits (>=1)
//  BUBBLE_DATA  {DATA_WIDTH{0}} payload value presented after reset/flush
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-high reset
//  flush      in   1           synchronous discard of all held entries
//  in_valid   in   1           upstream payload valid
//  in_ready   out  1           stage can accept (registered)
//  in_data    in   DATA_WIDTH  upstream payload
//  out_valid  out  1           downstream payload valid
//  out_ready  in   1           downstream accepts
//  out_data   out  DATA_WIDTH  payload to downstream (driven from main entry)
//  occupancy  out  2           entries held: 0, 1 or 2
//  stall_count out 32          cycles with out_valid & !out_ready (see CONFIGURATION)
// BEHAVIOUR
//  - Two entries: MAIN (drives out_*) and SKID. States EMPTY(0), ONE(1), FULL(2) = occupancy.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - in_ready = !skid_valid, registered; deasserts only in FULL.
//  - EMPTY: in_fire -> MAIN<=in_data, -> ONE.
//  - ONE: in_fire & out_fire -> MAIN<=in_data, stay ONE; in_fire & !out_fire -> SKID<=in_data,
//    -> FULL; !in_fire & out_fire -> -> EMPTY; otherwise hold.
//  - FULL: out_fire -> MAIN<=SKID, SKID cleared, -> ONE (no input accepted this cycle).
//  - Latency in_fire -> out_valid: 1 cycle. Throughput 1 payload/cycle in ONE. Strict FIFO order.
//  - out_data/out_valid change only on clock edges; no combinational in->out path; out_ready
//    does not combinationally affect in_ready.
//  - Payload held stable while out_valid & !out_ready.
//  - Entries not valid hold BUBBLE_DATA (both MAIN and SKID data reset/cleared to it).
//  - flush (priority over all handshakes): next cycle occupancy=0, out_valid=0, in_ready=1,
//    out_data=BUBBLE_DATA; concurrent in_fire is discarded, concurrent out_fire is still
//    counted as delivered by downstream.
//  - reset (async, any time incl. mid-transfer): out_valid=0, in_ready=1, occupancy=0,
//    out_data=BUBBLE_DATA, stall_count=0. First in_fire possible on first edge after release.
//  - in_valid with in_ready=0 is legal; upstream must hold payload until in_fire.
// CONFIGURATION
//  - PIPELINE_STALL_COUNTER_EN defined: stall_count increments each cycle with
//    out_valid & !out_ready, saturates at 32'hFFFF_FFFF, cleared by reset only (not flush).
//  - Not defined: stall_count tied to 32'h0, no counter flops synthesised.
// TESTING
//  - Reset: assert mid-FULL -> same cycle out_valid=0, in_ready=1, occupancy=0, out_data=BUBBLE_DATA.
//  - Streaming: in_valid=1 for data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles,
//    first 1 cycle after first in_fire, occupancy stays 1.
//  - Backpressure: send 0xA,0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held;
//    release out_ready -> 0xA then 0xB, in_ready=1 the cycle after 0xA delivered.
//  - Flush in FULL with in_valid=1 data 0xC -> next cycle occupancy=0, 0xC never appears.
//  - Random valid/ready (10k cycles) -> scoreboard in/out order and count match, no loss/dup.
//  - With PIPELINE_STALL_COUNTER_EN: hold out_ready=0 for 5 cycles with out_valid=1 ->
//    stall_count=5; flush -> stall_count stays 5; without macro -> stall_count=0.

Source files
------------

// File: rtl/pipeline_skid_register.sv
// Elastic valid/ready stage: 2-entry skid buffer, registered in_ready, flush to bubble.
// Optional stall counter enabled by defining PIPELINE_STALL_COUNTER_EN.
module pipeline_skid_register #(
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  output logic [31:0]           stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q;
  logic                  in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          main_d  = BUBBLE_DATA;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          skid_d  = BUBBLE_DATA;
          state_d = ONE;
        end
      end
      default: begin
        main_d  = BUBBLE_DATA;
        skid_d  = BUBBLE_DATA;
        state_d = EMPTY;
      end
    endcase
    // flush overrides whatever the handshakes decided
    if (flush) begin
      main_d  = BUBBLE_DATA;
      skid_d  = BUBBLE_DATA;
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE_DATA;
      skid_q     <= BUBBLE_DATA;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

`ifdef PIPELINE_STALL_COUNTER_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Randomized + directed bench for pipeline_skid_register against a queue model.
// Expects stall_count behaviour matching PIPELINE_STALL_COUNTER_EN.
module tb_pipeline_skid_register;

  localparam int DW = 64;
  localparam logic [DW-1:0] BUB = 64'h0000_0000_0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [31:0]   stall_count;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mq[$];
  longint unsigned m_stall = 0;
  int m_deliv = 0;
  int d_deliv = 0;

  always #5 clk = ~clk;

  pipeline_skid_register #(
    .DATA_WIDTH (DW),
    .BUBBLE_DATA(BUB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_stall();
`ifdef PIPELINE_STALL_COUNTER_EN
    return m_stall;
`else
    return 64'd0;
`endif
  endfunction

  task automatic check_outputs();
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_data", out_data, (mq.size() > 0) ? mq[0] : BUB);
    chk("stall_count", 64'(stall_count), exp_stall());
  endtask

  // one clock: drive, check at negedge, advance model at posedge
  task automatic step(input logic fl, input logic iv,
                      input logic [DW-1:0] id, input logic ordy);
    bit pop, push;
    flush = fl;
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    @(negedge clk);
    check_outputs();
    if (out_valid && out_ready) d_deliv++;
    pop  = (mq.size() > 0) && ordy;
    push = iv && (mq.size() < 2);
    if (mq.size() > 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
    @(posedge clk);
    if (pop) m_deliv++;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(id);
    end
    #1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    mq.delete();
    m_stall = 0;
    check_outputs();
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pend;
    bit            pend_v;
    bit            seen_c;

    reset = 1'b1;
    #12 reset = 1'b0;
    #1;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, DW'(i), 1'b1);
      if (i > 1) chk("stream_occ", 64'(occupancy), 64'd1);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // backpressure A,B then release
    step(1'b0, 1'b1, 64'hA, 1'b0);
    step(1'b0, 1'b1, 64'hB, 1'b0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_data", out_data, 64'hA);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("bp_ready_after_A", 64'(in_ready), 64'd1);
    chk("bp_data_B", out_data, 64'hB);
    step(1'b0, 1'b0, '0, 1'b1);

    // stall counter: 5 cycles held
    step(1'b0, 1'b1, 64'h55, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
    chk("stall5", 64'(stall_count), exp_stall());

    // flush in FULL with concurrent input 0xC
    step(1'b0, 1'b1, 64'h66, 1'b0);
    chk("full_before_flush", 64'(occupancy), 64'd2);
    step(1'b1, 1'b1, 64'hC, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_data", out_data, BUB);
    chk("flush_keeps_stall", 64'(stall_count), exp_stall());
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // async reset mid-FULL
    step(1'b0, 1'b1, 64'h77, 1'b0);
    step(1'b0, 1'b1, 64'h88, 1'b0);
    chk("pre_reset_full", 64'(occupancy), 64'd2);
    async_reset();
    step(1'b0, 1'b1, 64'h99, 1'b1);
    chk("first_after_reset", out_data, 64'h99);
    step(1'b0, 1'b0, '0, 1'b1);

    // random traffic; upstream holds payload until accepted
    pend_v = 0;
    pend = '0;
    seen_c = 0;
    for (int i = 0; i < 10000; i++) begin
      logic fl, iv, ordy;
      if (!pend_v && $urandom_range(0, 3) != 0) begin
        pend_v = 1;
        pend = {$urandom(), $urandom()};
      end
      iv = pend_v;
      ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 99) == 0);
      if (iv && in_ready) pend_v = 0;
      step(fl, iv, pend, ordy);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("deliver_count", 64'(d_deliv), 64'(m_deliv));
    chk("drained", 64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
